// File: rtl/pipe_fifo.sv
// rtl/pipe_fifo.sv - elastic first-word-fall-through pipeline buffer with valid/ready and flush
module pipe_fifo #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [$clog2(DEPTH):0] count,
    output logic             full,
    output logic             empty,
    output logic             almost_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [CW-1:0]    cnt;
    logic             push;
    logic             pop;

    // Status decode from occupancy only; in_ready never looks at out_ready
    always_comb begin
        empty       = (cnt == '0);
        full        = (cnt == DEPTH_C);
        almost_full = (cnt >= AF_C);
        in_ready    = !full;
        out_valid   = !empty;
        count       = cnt;
    end

    // Accepted transfers on each side
    always_comb begin
        push = in_valid & in_ready;
        pop  = out_valid & out_ready;
    end

    // Head entry, masked to zero when empty so stale storage never leaks
    always_comb begin
        out_data = '0;
        if (!empty) begin
            out_data = mem[rp];
        end
    end

    // Storage write; not reset, a flushed or in-reset push is simply dropped
    always_ff @(posedge clk) begin
        if (push && !clear && reset) begin
            mem[wp] <= in_data;
        end
    end

    // Pointers and occupancy; flush overrides any transfer in the same cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else if (clear) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) begin
                wp <= wp + AW'(1);
            end
            if (pop) begin
                rp <= rp + AW'(1);
            end
            if (push && !pop) begin
                cnt <= cnt + CW'(1);
            end else if (pop && !push) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: doc/pipe_fifo.md
# pipe_fifo

Parametrised elastic pipeline buffer: a DEPTH-entry, WIDTH-bit first-word-fall-through queue with valid/ready handshakes on both sides and a synchronous flush. It generalises the fixed single-entry clear-able flop into a back-pressure-capable stage register. It is used between pipeline stages, for example fetch-to-decode instruction buffering and store buffering, where a stall on one side must not drop data on the other.

## Interface
Parameters:
- WIDTH, 32, payload width in bits (≥1).
- DEPTH, 4, number of entries; power of two, ≥2.
- AF_LEVEL, DEPTH-1, occupancy at or above which almost_full asserts (1..DEPTH).
- Derived (localparam, not overridable): AW = log2(DEPTH), CW = AW+1.

Ports:
- clk, input, 1, single clock; all state changes on the rising edge.
- reset, input, 1, asynchronous, active-low reset (asserted when 0).
- clear, input, 1, synchronous flush; empties the buffer at the next edge.
- in_valid, input, 1, producer has data on in_data.
- in_ready, output, 1, buffer can accept; equals !full.
- in_data, input, WIDTH, write payload.
- out_valid, output, 1, head entry present; equals !empty.
- out_ready, input, 1, consumer accepts head this cycle.
- out_data, output, WIDTH, head entry payload; all-zero when empty.
- count, output, CW, current occupancy, 0..DEPTH.
- full, output, 1, count == DEPTH.
- empty, output, 1, count == 0.
- almost_full, output, 1, count ≥ AF_LEVEL.

## Operation
- push = in_valid & in_ready. pop = out_valid & out_ready.
- State: storage array mem[DEPTH], write pointer wp (AW bits), read pointer rp (AW bits), count (CW bits). Storage is not reset. wp, rp and count are reset.
- On push: mem[wp] ← in_data. wp ← wp+1 modulo DEPTH, with natural wrap.
- On pop: rp ← rp+1 modulo DEPTH.
- count update: push only → +1. Pop only → −1. Both, or neither → unchanged.
- Push and pop in the same cycle are legal whenever 0 < count < DEPTH.
- When count == 0, pop is impossible because out_valid = 0.
- When count == DEPTH, push is impossible because in_ready = 0. in_ready does not look ahead at out_ready, so there is no combinational path from out_ready to in_ready.
- out_data = mem[rp] when count ≠ 0, else 0. The output is combinational from registered state, with no path from in_data.
- Status outputs are decoded from count only: full, empty, almost_full, in_ready, out_valid.
- clear takes priority over push and pop in the same cycle. At the edge, wp, rp and count go to 0. Any accepted push that cycle is discarded.
- The producer may drop in_valid without a transfer. The buffer imposes no stability rule on the producer, but consumers rely on out_data holding stable while out_valid=1 and out_ready=0.

## Timing
- While reset=0, asynchronously: wp=rp=0 and count=0. As a result, empty=1, full=0, almost_full=0, out_valid=0, in_ready=1, out_data=0.
- Reset deassertion is synchronised externally. The first push is accepted at the first rising edge after reset=1.
- Latency: data pushed at edge N appears on out_data, with out_valid=1, after edge N, in the same cycle N+1. There is no combinational bypass when empty.
- Throughput: one push and one pop per cycle sustained.
- Full boundary: at count=DEPTH, in_ready is 0 for the cycle. A pop at edge N makes in_ready=1 from N+1.
- Empty boundary: at count=1 with pop and no push, out_valid=0 and out_data=0 after the edge.
- Wrap: the pointers roll from DEPTH−1 to 0 with no bubble. Order is preserved across the wrap.
- Reset mid-operation: contents are abandoned immediately, without waiting for a clock. Stale mem values are never visible because out_data is masked when empty.

## Test plan
- Reset/idle: hold reset=0 for 3 cycles with in_valid=1. Required: count=0, empty=1, in_ready=1, out_data=0, and no entry written after release until the first edge with reset=1.
- Fill/drain, DEPTH=4, WIDTH=32: push 0x11, 0x22, 0x33, 0x44 with out_ready=0. Required: count goes 1,2,3,4. almost_full asserts at count 3. full=1 and in_ready=0 at count 4. A 5th in_valid with 0x55 is not accepted. Then out_ready=1: out_data 0x11, 0x22, 0x33, 0x44 on consecutive cycles, then empty=1.
- Simultaneous push/pop: at count=2, push 0xA5 and pop together for 10 cycles. Required: count stays 2, FIFO order is kept, and data crosses the pointer wrap correctly.
- Full with pop: at count=4, assert out_ready=1 and in_valid=1 in the same cycle. Required: the pop occurs and the push does not, so count=3. in_ready=1 in the next cycle, and the push is then accepted.
- Clear priority: at count=3, assert clear=1 together with push 0x77 and out_ready=1. Required: after the edge, count=0, empty=1, out_data=0. The 0x77 is never output.
- Async reset mid-stream: at count=2, pull reset low between edges. Required: out_valid=0 and count=0 immediately, without waiting for a clock edge. After release, the next push is output as the sole entry.
